// File: rtl/serial_tx_arbiter_if.sv
// Bus bundle for serial_tx_arbiter: four requesters (req/len/sin) toward the arbiter, grant/serial stream back.
interface serial_tx_arbiter_if #(
  parameter int unsigned LEN_W = 8
);
  logic [3:0]         req;
  logic [4*LEN_W-1:0] len_bus;
  logic [3:0]         sin;
  logic [3:0]         gnt;
  logic               serial_out;
  logic               serout_ready;
  logic               wake_em_up;
  logic [3:0]         done;
  logic               busy;

  modport master (
    output req, len_bus, sin,
    input  gnt, serial_out, serout_ready, wake_em_up, done, busy
  );

  modport slave (
    input  req, len_bus, sin,
    output gnt, serial_out, serout_ready, wake_em_up, done, busy
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that serialises one variable-length frame at a time from four requesters.
// Optional trailing even-parity bit when TX_PARITY_EN is defined.
module serial_tx_arbiter #(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_tx_arbiter_if.slave bus
);

`ifdef TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_DONE = 2'd2, S_PAR = 2'd3} state_t;
  localparam state_t S_TAIL = S_PAR;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_DONE = 2'd2} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [1:0]       r_last, w_last_nxt;
  logic [1:0]       w_win;
  logic [LEN_W-1:0] w_win_len;
  logic             w_sin_bit;
`ifdef TX_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  // First requester found searching upward from last+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] cand;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) rr_pick = cand;
    end
  endfunction

  assign w_win     = rr_pick(r_last, bus.req);
  assign w_win_len = bus.len_bus[LEN_W*32'(w_win) +: LEN_W];
  assign w_sin_bit = bus.sin[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_last  <= 2'd3;
`ifdef TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
`ifdef TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_last_nxt       = r_last;
`ifdef TX_PARITY_EN
    w_par_nxt        = r_par;
`endif
    bus.gnt          = 4'b0000;
    bus.serial_out   = 1'b0;
    bus.serout_ready = 1'b0;
    bus.wake_em_up   = 1'b0;
    bus.done         = 4'b0000;
    bus.busy         = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_idx_nxt   = w_win;
          w_cnt_nxt   = w_win_len;
`ifdef TX_PARITY_EN
          w_par_nxt   = 1'b0;
`endif
          w_state_nxt = (w_win_len == '0) ? S_TAIL : S_SEND;
        end
      end
      S_SEND: begin
        bus.gnt          = 4'b0001 << r_idx;
        bus.serout_ready = 1'b1;
        bus.serial_out   = w_sin_bit;
`ifdef TX_PARITY_EN
        w_par_nxt        = r_par ^ w_sin_bit;
`else
        bus.wake_em_up   = (r_cnt == LEN_W'(1));
`endif
        // Counter saturates at zero so a corrupted zero count still ends the frame.
        if (r_cnt != '0) w_cnt_nxt = r_cnt - LEN_W'(1);
        if (r_cnt <= LEN_W'(1)) w_state_nxt = S_TAIL;
      end
`ifdef TX_PARITY_EN
      S_PAR: begin
        bus.gnt          = 4'b0001 << r_idx;
        bus.serout_ready = 1'b1;
        bus.serial_out   = r_par;
        bus.wake_em_up   = 1'b1;
        w_state_nxt      = S_DONE;
      end
`endif
      S_DONE: begin
        bus.gnt     = 4'b0001 << r_idx;
        bus.done    = 4'b0001 << r_idx;
        w_last_nxt  = r_idx;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
